// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Brief    : Shared types, constants and the prediction helper for the
//            self-synchronising PRBS checker.
// Revision : 1.0
// ============================================================================
package prbs_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next bit the generator would emit from this register contents.
  function automatic logic lfsr_parity(input logic [LFSR_W-1:0] sr,
                                       input logic [LFSR_W-1:0] tap_mask);
    return ^(sr & tap_mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Brief    : Self-synchronising checker for the 8-bit configurable LFSR
//            stream: seeds from received bits, hunts for lock, then counts
//            bit errors and drops lock on too many errors per window.
// Revision : 1.0
// ============================================================================
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic [LFSR_W-1:0]    tap,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int ERRS_W  = $clog2(UNLOCK_ERRS + 1);
  localparam int SEED_W  = $clog2(LFSR_W + 1);

  state_t                r_state;
  logic [LFSR_W-1:0]     r_sr;
  logic [LFSR_W-1:0]     r_tap_q;
  logic [SEED_W-1:0]     r_seed_cnt;
  logic [MATCH_W-1:0]    r_match_cnt;
  logic [WIN_W-1:0]      r_win_cnt;
  logic [ERRS_W-1:0]     r_win_errs;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic                  r_locked;
  logic                  r_err_pulse;

  state_t                w_state_nxt;
  logic [LFSR_W-1:0]     w_sr_nxt;
  logic [SEED_W-1:0]     w_seed_nxt;
  logic [MATCH_W-1:0]    w_match_nxt;
  logic [WIN_W-1:0]      w_win_nxt;
  logic [ERRS_W-1:0]     w_errs_nxt;
  logic [CNT_WIDTH-1:0]  w_err_cnt_nxt;
  logic                  w_err;

  logic                  w_exp;
  logic                  w_mismatch;
  logic                  w_tap_chg;
  logic [MATCH_W-1:0]    w_match_inc;
  logic [WIN_W-1:0]      w_win_inc;
  logic [ERRS_W-1:0]     w_errs_inc;

  assign w_exp       = lfsr_parity(r_sr, r_tap_q);
  assign w_mismatch  = (in_bit != w_exp);
  assign w_tap_chg   = (tap != r_tap_q);
  assign w_match_inc = r_match_cnt + MATCH_W'(1);
  assign w_win_inc   = r_win_cnt + WIN_W'(1);
  assign w_errs_inc  = r_win_errs + ERRS_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_seed_nxt    = r_seed_cnt;
    w_match_nxt   = r_match_cnt;
    w_win_nxt     = r_win_cnt;
    w_errs_nxt    = r_win_errs;
    w_err         = 1'b0;

    // Every received bit is shifted in regardless of state: this is what
    // makes the checker resynchronise on its own.
    if (in_valid) begin
      w_sr_nxt = {r_sr[LFSR_W-2:0], in_bit};
    end

    case (r_state)
      SEED: begin
        if (in_valid) begin
          if (r_seed_cnt != SEED_W'(LFSR_W)) begin
            w_seed_nxt = r_seed_cnt + SEED_W'(1);
          end
          // An all-zero mask would predict a constant; never leave SEED on it.
          if ((r_seed_cnt >= SEED_W'(LFSR_W - 1)) && (r_tap_q != '0)) begin
            w_state_nxt = HUNT;
            w_match_nxt = '0;
          end
        end
      end

      HUNT: begin
        if (w_tap_chg) begin
          w_state_nxt = SEED;
          w_seed_nxt  = '0;
        end else if (in_valid) begin
          if (w_mismatch) begin
            w_match_nxt = '0;
          end else if (w_match_inc == MATCH_W'(LOCK_COUNT)) begin
            w_state_nxt = LOCKED;
            w_match_nxt = '0;
            w_win_nxt   = '0;
            w_errs_nxt  = '0;
          end else begin
            w_match_nxt = w_match_inc;
          end
        end
      end

      LOCKED: begin
        if (w_tap_chg) begin
          w_state_nxt = SEED;
          w_seed_nxt  = '0;
        end else if (in_valid) begin
          w_win_nxt = w_win_inc;
          if (w_mismatch) begin
            w_err      = 1'b1;
            w_errs_nxt = w_errs_inc;
          end
          // Loss of lock wins over the window roll on the same bit.
          if (w_mismatch && (w_errs_inc == ERRS_W'(UNLOCK_ERRS))) begin
            w_state_nxt = SEED;
            w_seed_nxt  = '0;
          end else if (w_win_inc == WIN_W'(WINDOW)) begin
            w_win_nxt  = '0;
            w_errs_nxt = '0;
          end
        end
      end

      default: begin
        w_state_nxt = SEED;
        w_seed_nxt  = '0;
      end
    endcase

    if (clear_cnt) begin
      w_err_cnt_nxt = w_err ? CNT_WIDTH'(1) : '0;
    end else if (w_err && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
      w_err_cnt_nxt = r_err_cnt + CNT_WIDTH'(1);
    end else begin
      w_err_cnt_nxt = r_err_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEED;
      r_sr        <= '0;
      r_tap_q     <= '0;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_errs  <= '0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_tap_q     <= tap;
      r_seed_cnt  <= w_seed_nxt;
      r_match_cnt <= w_match_nxt;
      r_win_cnt   <= w_win_nxt;
      r_win_errs  <= w_errs_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_err_pulse <= w_err;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prbs_checker
// Brief    : Scoreboard bench for prbs_checker with directed bit streams.
// Revision : 1.0
// ============================================================================
module tb_prbs_checker;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_bit;
  logic [7:0]    tap;
  logic          clear_cnt;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_cnt;

  prbs_checker #(
    .LOCK_COUNT (16),
    .WINDOW     (64),
    .UNLOCK_ERRS(6),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .tap      (tap),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          l;
    logic          p;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  string         phase = "init";
  logic [7:0]    gen_state;
  logic [CW-1:0] m_cnt;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s phase=%s cyc=%0d actual=%0d required=%0d", nm, phase, cyc, act, req);
    end
  endtask

  task automatic push(input logic l, input logic p, input logic [CW-1:0] c);
    exp_t e;
    e.l = l; e.p = p; e.c = c;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs settle after each rising edge; one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("locked", {7'd0, locked}, {7'd0, e.l});
        cmp("err_pulse", {7'd0, err_pulse}, {7'd0, e.p});
        cmp("err_cnt", {4'd0, err_cnt}, {4'd0, e.c});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    clear_cnt = 1'b0;
    m_cnt     = '0;
    push(1'b0, 1'b0, '0);
  endtask

  // One cycle of stimulus; exp_l / exp_e are the hand-derived lock state
  // and "a counted mismatch happens on this bit".
  task automatic step(input logic v, input logic flip, input logic clr,
                      input logic [7:0] dtap, input logic [7:0] gtap,
                      input logic exp_l, input logic exp_e);
    logic fb;
    @(negedge clk);
    reset     = 1'b0;
    tap       = dtap;
    clear_cnt = clr;
    in_valid  = v;
    if (v) begin
      fb        = ^(gen_state & gtap);
      gen_state = {gen_state[6:0], fb};
      in_bit    = fb ^ flip;
    end else begin
      in_bit = 1'b0;
    end
    if (clr) m_cnt = exp_e ? CW'(1) : '0;
    else if (exp_e && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
    push(exp_l, exp_e, m_cnt);
  endtask

  initial begin
    logic fl, er, cl, ll;
    int   vc;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; tap = 8'hB8; clear_cnt = 1'b0;
    gen_state = 8'h01;
    m_cnt = '0;

    phase = "reset";
    repeat (2) do_reset();

    // Continuous B8 stream: lock at bit 24, windows close at 24+64k.
    // Flip at t gives mismatches at t, t+4, t+5, t+6, t+8 (taps 3,4,5,7).
    for (int n = 1; n <= 1240; n++) begin
      if (n == 1) phase = "clean_lock";
      if (n == 1001) phase = "single_err";
      if (n == 1049) phase = "loss_of_lock";
      if (n == 1105) phase = "saturate";
      if (n == 1169) phase = "clear_cnt";
      fl = (n inside {1010, 1060, 1080, 1120, 1180});
      er = (n inside {1010, 1014, 1015, 1016, 1018,
                      1060, 1064, 1065, 1066, 1068, 1080,
                      1120, 1124, 1125, 1126, 1128,
                      1180, 1184, 1185, 1186, 1188});
      cl = (n == 1180) || (n == 1200);
      ll = ((n >= 24) && (n < 1080)) || (n >= 1104);
      step(1'b1, fl, cl, 8'hB8, 8'hB8, ll, er);
    end

    phase = "reset_mid_locked";
    do_reset();
    gen_state = 8'h01;

    phase = "gapped";
    vc = 0;
    for (int k = 0; k < 80; k++) begin
      if ((k % 2) == 0) vc++;
      step((k % 2) == 0, 1'b0, 1'b0, 8'hB8, 8'hB8, vc >= 24, 1'b0);
    end

    phase = "tap_change";
    for (int r = 0; r < 40; r++) begin
      step(1'b1, 1'b0, 1'b0, 8'h8E, 8'h8E, r >= 24, 1'b0);
    end

    phase = "tap_zero";
    for (int r = 0; r < 40; r++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h8E, 1'b0, 1'b0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    phase = "drain";
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
